// File: rtl/jk_cnt_pkg.sv
// rtl/jk_cnt_pkg.sv - shared JK encodings, default width and command helpers for the JK down counter
package jk_cnt_pkg;

  // {J,K} pair as seen at a JK flip-flop input
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  localparam int DEFAULT_CNT_WIDTH = 3;

  // Force a flop to a given value regardless of its current state.
  function automatic jk_cmd_e jk_force_cmd(input logic bit_val);
    return bit_val ? JK_SET : JK_RESET;
  endfunction

  // Toggle when asked, otherwise hold.
  function automatic jk_cmd_e jk_toggle_cmd(input logic do_toggle);
    return do_toggle ? JK_TOGGLE : JK_HOLD;
  endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// rtl/jk_ff_sync.sv - single JK flip-flop with synchronous active-low reset
module jk_ff_sync
  import jk_cnt_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (jk_cmd_e'({J, K}))
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/jk_sync_down_counter.sv
// rtl/jk_sync_down_counter.sv - synchronous JK down counter with load and borrow; JK_DOWN_AUTORELOAD_EN adds underflow reload
module jk_sync_down_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic             borrow_q;
  logic             borrow_d;
  logic             underflow;
  logic             low_zero;

  assign underflow = en & ~load & (count_q == '0);

`ifdef JK_DOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;

  always_comb begin
    reload_d = reload_q;
    if (load) begin
      reload_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      reload_q <= '1;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // A down count toggles bit i once every lower bit is already zero.
  always_comb begin
    j_d      = '0;
    k_d      = '0;
    low_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (load) begin
        {j_d[i], k_d[i]} = jk_force_cmd(load_val[i]);
`ifdef JK_DOWN_AUTORELOAD_EN
      end else if (underflow) begin
        {j_d[i], k_d[i]} = jk_force_cmd(reload_q[i]);
`endif
      end else begin
        {j_d[i], k_d[i]} = jk_toggle_cmd(en & low_zero);
      end
      low_zero = low_zero & ~count_q[i];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_ff_sync u_ff (
      .clk   (clk),
      .reset (reset),
      .J     (j_d[g]),
      .K     (k_d[g]),
      .Q     (count_q[g])
    );
  end

  always_comb begin
    borrow_d = underflow;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      borrow_q <= 1'b0;
    end else begin
      borrow_q <= borrow_d;
    end
  end

  assign count  = count_q;
  assign zero   = (count_q == '0);
  assign borrow = borrow_q;

endmodule

// File: tb/tb_jk_sync_down_counter.sv
// tb/tb_jk_sync_down_counter.sv - scoreboard bench for jk_sync_down_counter at WIDTH=3
module tb_jk_sync_down_counter;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         zero;
  logic         borrow;

  typedef struct {
    logic [W-1:0] c;
    logic         z;
    logic         b;
    string        tag;
  } exp_t;

  exp_t         sb_q[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] m_cnt = '0;
  logic [W-1:0] m_rel = '1;

  jk_sync_down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .zero     (zero),
    .borrow   (borrow)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    tests++;
    assert (count === e.c) else begin
      fails++;
      $error("FAIL %s.count observed=%0d expected=%0d", e.tag, count, e.c);
    end
    tests++;
    assert (zero === e.z) else begin
      fails++;
      $error("FAIL %s.zero observed=%0b expected=%0b", e.tag, zero, e.z);
    end
    tests++;
    assert (borrow === e.b) else begin
      fails++;
      $error("FAIL %s.borrow observed=%0b expected=%0b", e.tag, borrow, e.b);
    end
  endtask

  // Drive one cycle, predict its outcome arithmetically, then compare after the edge.
  task automatic step(input logic r, input logic e_in, input logic l,
                      input logic [W-1:0] lv, input string tag);
    exp_t         x;
    logic [W-1:0] nc;
    logic [W-1:0] nr;
    logic         nb;
    reset    = r;
    en       = e_in;
    load     = l;
    load_val = lv;
    nc = m_cnt;
    nr = m_rel;
    nb = 1'b0;
    if (!r) begin
      nc = '0;
      nr = '1;
    end else if (l) begin
      nc = lv;
      nr = lv;
    end else if (e_in) begin
      if (m_cnt == 0) begin
        nb = 1'b1;
`ifdef JK_DOWN_AUTORELOAD_EN
        nc = m_rel;
`else
        nc = W'((1 << W) - 1);
`endif
      end else begin
        nc = m_cnt - 1'b1;
      end
    end
    x.c   = nc;
    x.z   = (nc == 0);
    x.b   = nb;
    x.tag = tag;
    sb_q.push_back(x);
    m_cnt = nc;
    m_rel = nr;
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b1;
    load     = 1'b1;
    load_val = 3'd5;

    step(1'b0, 1'b1, 1'b1, 3'd5, "reset0");
    step(1'b0, 1'b1, 1'b1, 3'd5, "reset1");

    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'd0, $sformatf("freerun%0d", i));
    end

    step(1'b1, 1'b0, 1'b1, 3'd2, "prio_setup");
    step(1'b1, 1'b1, 1'b1, 3'd5, "prio_load");
    step(1'b1, 1'b1, 1'b0, 3'd0, "prio_dec");

    step(1'b1, 1'b0, 1'b1, 3'd3, "hold_setup");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 3'd6, $sformatf("hold%0d", i));
    end
    step(1'b1, 1'b1, 1'b0, 3'd0, "hold_release");

    step(1'b1, 1'b0, 1'b1, 3'd0, "midrst_setup");
    step(1'b0, 1'b1, 1'b0, 3'd0, "midrst");

    step(1'b1, 1'b1, 1'b1, 3'd2, "reload_load");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'd0, $sformatf("reload%0d", i));
    end

    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
